// File: rtl/timekeep_pkg.sv
// timekeep_pkg: digit indices, per-digit BCD maximums and digit-count helper
// shared by the timekeeper datapath and its digit cells.
package timekeep_pkg;
    localparam int SONES = 0;
    localparam int STENS = 1;
    localparam int MONES = 2;
    localparam int MTENS = 3;
    localparam int HONES = 4;
    localparam int HTENS = 5;
    localparam logic [3:0] SONES_MAX = 4'd9;
    localparam logic [3:0] STENS_MAX = 4'd5;
    localparam logic [3:0] MONES_MAX = 4'd9;
    localparam logic [3:0] MTENS_MAX = 4'd5;
    localparam logic [3:0] HONES_MAX = 4'd9;

    function automatic int ndig(input int has_hours);
        return has_hours != 0 ? 6 : 4;
    endfunction

    function automatic logic [3:0] dmax(input int i, input int hour_max);
        return i == HTENS ? 4'(hour_max / 10) :
               i == HONES ? HONES_MAX :
               i == MTENS ? MTENS_MAX :
               i == MONES ? MONES_MAX :
               i == STENS ? STENS_MAX : SONES_MAX;
    endfunction
endpackage

// File: rtl/bcd_updown_digit.sv
// bcd_updown_digit: one BCD digit counting up or down within 0..mx, with a
// clamped load, a synchronous clear and a carry/borrow-out flag.
module bcd_updown_digit (
    input  logic       clk,
    input  logic       rst,
    input  logic       cnt,
    input  logic       up,
    input  logic       zro,
    input  logic       ld,
    input  logic [3:0] ld_num,
    input  logic [3:0] mx,
    output logic [3:0] q,
    output logic       co
);
    always_ff @(posedge clk or posedge rst)
        if (rst) q <= '0;
        else if (ld) q <= ld_num > mx ? mx : ld_num;
        else if (zro) q <= '0;
        else if (cnt) q <= up ? (q >= mx ? 4'd0 : q + 4'd1) : (q == 4'd0 ? mx : q - 4'd1);

    assign co = up ? q >= mx : q == 4'd0;
endmodule

// File: rtl/bcd_timekeeper_dp.sv
// bcd_timekeeper_dp: HH:MM:SS or MM:SS BCD up/down timekeeper with clamped
// per-digit load, wrap/expiry pulses and a display digit selector.
module bcd_timekeeper_dp
    import timekeep_pkg::*;
#(
    parameter int HAS_HOURS = 1,
    parameter int HOUR_MAX = 23,
    localparam int NDIG = ndig(HAS_HOURS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              tick,
    input  logic              run,
    input  logic              dir,
    input  logic              ld_en,
    input  logic [2:0]        ld_sel,
    input  logic [3:0]        ld_num,
    input  logic              disp_adv,
    input  logic              pulse_in,
    input  logic              alarm_flash,
    output logic [4*NDIG-1:0] o_digits,
    output logic              o_wrap,
    output logic              o_expired,
    output logic              o_pulse,
    output logic [4:0]        led
);
    logic [3:0] d [6];
    logic [5:0] co;
    logic [6:0] c;
    logic [6:0] hrs;
    logic [2:0] sel;
    logic cen, step, wrap_n, exp_n;

    assign cen = tick & run & ~ld_en;
    always_comb begin
        c[0] = 1'b1;
        for (int k = 0; k < 6; k++) c[k+1] = c[k] & co[k];
    end
    // Down-counting parks at all zeros: c[6] is a borrow through every digit.
    assign step = cen & ~(~dir & c[6]);
    assign hrs = 7'(d[HTENS]) * 7'd10 + 7'(d[HONES]);
    assign wrap_n = step & dir & c[HONES] & (HAS_HOURS == 0 || hrs >= 7'(HOUR_MAX));
    assign exp_n = step & ~dir & (d[SONES] == 4'd1) &
                   ~|{d[HTENS], d[HONES], d[MTENS], d[MONES], d[STENS]};

    for (genvar i = 0; i < 6; i++) begin : g_dig
        if (i < NDIG) begin : g_on
            bcd_updown_digit u_dig (
                .clk    (clk),
                .rst    (rst),
                .cnt    (step & c[i]),
                .up     (dir),
                .zro    (i >= HONES && wrap_n),
                .ld     (ld_en && ld_sel == 3'(i)),
                .ld_num (ld_num),
                .mx     (dmax(i, HOUR_MAX)),
                .q      (d[i]),
                .co     (co[i])
            );
            assign o_digits[4*i +: 4] = d[i];
        end else begin : g_off
            assign d[i] = '0;
            assign co[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            sel <= '0;
            o_wrap <= 1'b0;
            o_expired <= 1'b0;
        end else begin
            sel <= disp_adv ? (sel == 3'(NDIG - 1) ? 3'd0 : sel + 3'd1) : sel;
            o_wrap <= wrap_n;
            o_expired <= exp_n;
        end

    assign o_pulse = pulse_in | ~run;
    assign led = alarm_flash ? {5{pulse_in}} : {o_pulse, d[sel]};
endmodule

// File: tb/tb_bcd_timekeeper_dp.sv
// tb_bcd_timekeeper_dp: scoreboard bench driving a 6-digit and a 4-digit
// timekeeper in lockstep against a seconds/minutes/hours reference model.
module tb_bcd_timekeeper_dp;
    localparam int HMAX = 23;

    logic clk = 1'b0, rst = 1'b1, tick = 1'b0, run = 1'b1, dir = 1'b1, ld_en = 1'b0;
    logic disp_adv = 1'b0, pulse_in = 1'b0, alarm_flash = 1'b0;
    logic [2:0] ld_sel = '0;
    logic [3:0] ld_num = '0;
    logic [23:0] dig6;
    logic [15:0] dig4;
    logic wrap6, wrap4, exp6, exp4, pul6, pul4;
    logic [4:0] led6, led4;

    logic [23:0] v6 = '0, v4 = '0;
    int sel6 = 0, sel4 = 0;
    bit w6, w4, e6, e4;
    logic [31:0] exp_q [$];
    int checks = 0, failures = 0;

    always #5 clk = ~clk;

    bcd_timekeeper_dp #(.HAS_HOURS(1), .HOUR_MAX(HMAX)) dut6 (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .dir(dir), .ld_en(ld_en),
        .ld_sel(ld_sel), .ld_num(ld_num), .disp_adv(disp_adv), .pulse_in(pulse_in),
        .alarm_flash(alarm_flash), .o_digits(dig6), .o_wrap(wrap6), .o_expired(exp6),
        .o_pulse(pul6), .led(led6)
    );

    bcd_timekeeper_dp #(.HAS_HOURS(0), .HOUR_MAX(HMAX)) dut4 (
        .clk(clk), .rst(rst), .tick(tick), .run(run), .dir(dir), .ld_en(ld_en),
        .ld_sel(ld_sel), .ld_num(ld_num), .disp_adv(disp_adv), .pulse_in(pulse_in),
        .alarm_flash(alarm_flash), .o_digits(dig4), .o_wrap(wrap4), .o_expired(exp4),
        .o_pulse(pul4), .led(led4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [23:0] enc(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    function automatic logic [25:0] nxt(input logic [23:0] v, input int nd, input bit up);
        int s, m, h;
        bit w, e;
        s = int'(v[7:4]) * 10 + int'(v[3:0]);
        m = int'(v[15:12]) * 10 + int'(v[11:8]);
        h = int'(v[23:20]) * 10 + int'(v[19:16]);
        w = 1'b0;
        e = 1'b0;
        if (up) begin
            if (s < 59) s++;
            else begin
                s = 0;
                if (m < 59) m++;
                else begin
                    m = 0;
                    if (nd == 4 || h >= HMAX) begin h = 0; w = 1'b1; end
                    else h++;
                end
            end
        end else if (s + m + h != 0) begin
            if (s > 0) s--;
            else begin
                s = 59;
                if (m > 0) m--;
                else begin m = 59; h--; end
            end
            e = (s + m + h == 0);
        end
        return {w, e, enc(h, m, s)};
    endfunction

    function automatic logic [23:0] ldm(input logic [23:0] v, input int nd, input logic [2:0] ls, input logic [3:0] ln);
        int mx;
        mx = ls == 3'd5 ? HMAX / 10 : (ls == 3'd1 || ls == 3'd3) ? 5 : 9;
        if (int'(ls) < nd) v[4*ls +: 4] = int'(ln) > mx ? 4'(mx) : ln;
        return v;
    endfunction

    function automatic logic [31:0] pack(input logic [23:0] v, input int sel, input bit w, input bit e);
        logic op;
        op = pulse_in | ~run;
        return {op, alarm_flash ? {5{pulse_in}} : {op, v[4*sel +: 4]}, w, e, v};
    endfunction

    task automatic push_exp();
        exp_q.push_back(pack(v6, sel6, w6, e6));
        exp_q.push_back(pack(v4, sel4, w4, e4));
    endtask

    task automatic pop_cmp(input string tag);
        check({tag, "/6"}, {pul6, led6, wrap6, exp6, dig6}, exp_q.pop_front());
        check({tag, "/4"}, {pul4, led4, wrap4, exp4, 8'h00, dig4}, exp_q.pop_front());
    endtask

    task automatic cyc(input bit tk, input bit ld, input logic [2:0] ls, input logic [3:0] ln,
                       input bit adv, input string tag);
        logic [25:0] r;
        tick = tk; ld_en = ld; ld_sel = ls; ld_num = ln; disp_adv = adv;
        w6 = 0; e6 = 0; w4 = 0; e4 = 0;
        if (ld) begin
            v6 = ldm(v6, 6, ls, ln);
            v4 = ldm(v4, 4, ls, ln);
        end else if (tk && run) begin
            r = nxt(v6, 6, dir); {w6, e6, v6} = r;
            r = nxt(v4, 4, dir); {w4, e4, v4} = r;
        end
        if (adv) begin
            sel6 = (sel6 + 1) % 6;
            sel4 = (sel4 + 1) % 4;
        end
        push_exp();
        @(posedge clk); #1;
        tick = 0; ld_en = 0; disp_adv = 0;
        pop_cmp(tag);
    endtask

    task automatic model_reset();
        v6 = '0; v4 = '0; sel6 = 0; sel4 = 0; w6 = 0; w4 = 0; e6 = 0; e4 = 0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        push_exp(); pop_cmp("reset");

        cyc(0, 1, 3'd0, 4'd9, 0, "ld_s1"); cyc(0, 1, 3'd1, 4'd5, 0, "ld_s10");
        cyc(0, 1, 3'd2, 4'd9, 0, "ld_m1"); cyc(0, 1, 3'd3, 4'd5, 0, "ld_m10");
        cyc(0, 1, 3'd4, 4'd3, 0, "ld_h1"); cyc(0, 1, 3'd5, 4'd2, 0, "ld_h10");
        cyc(1, 0, 3'd0, 4'd0, 0, "wrap");
        cyc(0, 0, 3'd0, 4'd0, 0, "wrap_off");

        dir = 1'b0;
        cyc(0, 1, 3'd0, 4'd1, 0, "ld_0001");
        cyc(1, 0, 3'd0, 4'd0, 0, "expire");
        cyc(1, 0, 3'd0, 4'd0, 0, "hold_zero");
        cyc(0, 1, 3'd1, 4'd7, 0, "clamp_s10");
        cyc(0, 1, 3'd6, 4'd3, 0, "sel6_ignored");
        cyc(0, 1, 3'd4, 4'd7, 0, "ld_h1_only6");
        cyc(0, 1, 3'd5, 4'd9, 0, "clamp_h10");

        cyc(0, 1, 3'd1, 4'd0, 0, "clr_s10"); cyc(0, 1, 3'd4, 4'd0, 0, "clr_h1");
        cyc(0, 1, 3'd5, 4'd0, 0, "clr_h10"); cyc(0, 1, 3'd0, 4'd8, 0, "ld_08");
        dir = 1'b1;
        cyc(1, 1, 3'd0, 4'd3, 0, "tick_vs_ld");

        dir = 1'b0;
        cyc(0, 1, 3'd0, 4'd0, 0, "ld_s0"); cyc(0, 1, 3'd4, 4'd1, 0, "ld_h1");
        cyc(1, 0, 3'd0, 4'd0, 0, "borrow_hour");

        dir = 1'b1;
        cyc(0, 1, 3'd5, 4'd2, 0, "h10_2"); cyc(0, 1, 3'd4, 4'd9, 0, "h1_9");
        cyc(1, 0, 3'd0, 4'd0, 0, "over_max_wrap");

        for (int n = 0; n < 60; n++) begin
            dir = 1'($urandom_range(0, 1));
            cyc(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)),
                4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), "rand");
        end

        run = 1'b0;
        pulse_in = 1'b0;
        for (int n = 0; n < 3; n++) cyc(1, 0, 3'd0, 4'd0, 0, "frozen");
        run = 1'b1;
        for (int n = 0; n < 6; n++) cyc(0, 0, 3'd0, 4'd0, 1, "disp_adv");
        pulse_in = 1'b1;
        #1 push_exp(); pop_cmp("led_sones");

        dir = 1'b1;
        cyc(1, 0, 3'd0, 4'd0, 1, "pre_rst");
        @(posedge clk); #3 rst = 1'b1;
        model_reset();
        #1 push_exp(); pop_cmp("async_rst");
        @(posedge clk); #2 rst = 1'b0;
        cyc(1, 0, 3'd0, 4'd0, 0, "first_tick");

        alarm_flash = 1'b1;
        for (int n = 0; n < 4; n++) begin
            pulse_in = ~pulse_in;
            #2 push_exp(); pop_cmp("flash");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bcd_timekeeper_dp.md
# bcd_timekeeper_dp

Parametrised BCD timekeeping datapath: the successor to the minutes/seconds clock datapath. Adds an optional hours field, up/down counting with countdown expiry, per-digit clamped loading and a display selector over all digits. It sits between the one-second strobe generator and the 5-bit LED output, and is driven by the clock control FSM.

## Interface

Parameters:
- HAS_HOURS, 1: 1 gives 6 digits (HH:MM:SS); 0 gives 4 digits (MM:SS). NDIG = HAS_HOURS ? 6 : 4.
- HOUR_MAX, 23: highest hour value, 1..99; the count wraps or borrows at this value.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- tick  in  1  one-second strobe, one clk wide.
- run  in  1  1 = count; 0 = freeze.
- dir  in  1  1 = count up; 0 = count down.
- ld_en  in  1  load strobe.
- ld_sel  in  3  digit index: 0 Sones, 1 Stens, 2 Mones, 3 Mtens, 4 Hones, 5 Htens.
- ld_num  in  4  BCD value to load.
- disp_adv  in  1  advance the display selector.
- pulse_in  in  1  0.5 s on / 0.5 s off square wave.
- alarm_flash  in  1  force the LEDs to flash.
- o_digits  out  4*NDIG  digit i sits at bits [4i+3:4i].
- o_wrap  out  1  one-cycle pulse on an up-count wrap to all zeros.
- o_expired  out  1  one-cycle pulse when a down-count reaches all zeros.
- o_pulse  out  1  = pulse_in | ~run.
- led  out  5  display output.

## Operation

- Digit maximums:
  - Sones 9, Stens 5, Mones 9, Mtens 5.
  - Hones 9, Htens HOUR_MAX/10.
  - Hours as a pair range 00..HOUR_MAX.
- Count enable: cen = tick & run & ~ld_en. If a tick coincides with ld_en, the load is performed and the tick is dropped.
- Up count (dir=1):
  - Sones increments. A digit carries when it is at its max and every lower digit carries.
  - The hours pair wraps to 00 when hours >= HOUR_MAX and MM:SS = 59:59.
  - Full wrap (HAS_HOURS=1: HOUR_MAX:59:59; HAS_HOURS=0: 59:59) goes to all zeros and sets o_wrap for one cycle.
- Down count (dir=0):
  - A digit at 0 borrows and reloads its max.
  - The hours pair at 00 is never borrowed from. The count is held at zero instead.
  - The transition to all zeros pulses o_expired once.
  - Further ticks at all zeros while dir=0 have no effect and produce no pulse.
- Load:
  - ld_en writes min(ld_num, digit max) into digit ld_sel.
  - An ld_sel of NDIG or higher is ignored.
  - Hours pairs above HOUR_MAX are legal after a load; the next up-count carry into hours wraps the pair to 00.
- Display selector sel:
  - disp_adv increments sel from 0 to NDIG-1, then wraps to 0.
- LED output:
  - alarm_flash=1: led = {5{pulse_in}}.
  - Otherwise: led = {o_pulse, digit[sel]}.
- Reset: all digits 0, sel 0, o_wrap 0, o_expired 0.

## Timing

- Digits update on the clk edge that samples cen (or ld_en); the new value is visible one cycle later.
- o_wrap and o_expired are registered and assert in the same cycle that o_digits shows zero.
- led and o_pulse are combinational from registered state and inputs, with zero cycles of latency.
- Reset assertion mid-count clears all state immediately, without waiting for clk. The first tick after reset deasserts is honoured.
- Changing dir between ticks takes effect on the next tick. No state is held about the previous direction.

## Structure

- Package timekeep_pkg holds:
  - digit index constants (SONES..HTENS);
  - per-digit max constants;
  - a function ndig(HAS_HOURS).
- Sub-module bcd_updown_digit holds one 4-bit digit:
  - up/down, load, and a max input;
  - a carry/borrow-out output.
- Six instances of bcd_updown_digit are generated, with the hour instances under HAS_HOURS.
- Hours wrap and borrow logic and zero detection live at the top level.

## Test plan

- Reset, HAS_HOURS=1, HOUR_MAX=23, load 23:59:59, dir=1, one tick -> o_digits = 00:00:00 and o_wrap pulses once.
- HAS_HOURS=0, load 00:01 and 00:00 via ld, dir=0, two ticks -> 00:00, 00:00; o_expired pulses on the first tick only.
- ld_sel=1, ld_num=7 -> Stens=5; ld_sel=6 with HAS_HOURS=0 -> no change.
- tick and ld_en in the same cycle (ld_sel=0, ld_num=3) from 00:00:08 -> 00:00:03, not 00:00:09.
- With run=0, 3 ticks -> digits unchanged and o_pulse=1. Then 6 disp_adv pulses -> sel returns to 0, and led = {pulse_in, Sones}.
- rst asserted between clk edges mid-count -> o_digits=0 and sel=0 before the next edge. With alarm_flash=1 after reset, led toggles 5'b11111 and 5'b00000 with pulse_in.
